ahb_fifo_writer: RTL and testbench
==================================

# ahb_fifo_writer

AHB-Lite slave front end of the AHB-to-SPI bridge, running entirely in the write-clock domain. It converts each accepted AHB-Lite transfer into a 41-bit command word and pushes it into the write port of the command async FIFO. It stalls the bus with wait states while that FIFO is full. For reads, it holds the data phase until the read-data word returns through the response async FIFO, then completes the transfer with that data.

## Interface
- DATA_WIDTH, 41: command word width; fixed layout {rw[40], addr[39:32], wdata[31:0]}.
- ADDR_BITS, 8: number of HADDR LSBs carried in the command.
- wr_clk  in  1  write-domain clock; all logic is synchronous to it.
- wr_rst  in  1  reset: asynchronous, active-high.
- HSEL  in  1  slave select.
- HADDR  in  32  transfer address; only [ADDR_BITS-1:0] is used.
- HTRANS  in  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  transfer size; only 3'b010 (word) is legal.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready, used for address-phase qualification.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.
- fifo_wr_en  out  1  command FIFO push strobe.
- fifo_wr_data  out  41  command word.
- fifo_full  in  1  command FIFO full (write domain).
- rsp_rd_en  out  1  response FIFO pop strobe.
- rsp_data  in  32  response FIFO read data; valid the cycle after rsp_rd_en.
- rsp_empty  in  1  response FIFO empty (write domain).

## Operation
- **Address phase accept:**
  - A transfer is accepted when HSEL & HTRANS[1] & HREADY.
  - On accept, the block registers HWRITE, HADDR[ADDR_BITS-1:0], and legality.
  - A transfer is legal when HSIZE==3'b010 and HADDR[1:0]==2'b00.
- **FSM states:** IDLE, WR, RD_CMD, RD_WAIT, RD_DATA, ERR1, ERR2.
- **IDLE:**
  - Drives HREADYOUT=1, HRESP=0.
  - On accept: illegal → ERR1; legal write → WR; legal read → RD_CMD.
- **WR:**
  - If !fifo_full: fifo_wr_en=1, fifo_wr_data={1'b1, addr, HWDATA}, HREADYOUT=1.
  - If fifo_full: HREADYOUT=0, no push, stay in WR.
- **RD_CMD:**
  - HREADYOUT=0 throughout.
  - If !fifo_full: fifo_wr_en=1, fifo_wr_data={1'b0, addr, 32'h0}, then → RD_WAIT.
  - Otherwise stay in RD_CMD.
- **RD_WAIT:**
  - HREADYOUT=0.
  - When !rsp_empty: rsp_rd_en=1 for exactly one cycle, then → RD_DATA.
- **RD_DATA:**
  - HREADYOUT=1, HRESP=0, HRDATA=rsp_data.
  - Outside RD_DATA, HRDATA=32'h0.
- **ERR1:** HREADYOUT=0, HRESP=1 → ERR2.
- **ERR2:** HREADYOUT=1, HRESP=1. No FIFO activity for an illegal transfer.
- **Pipelining:**
  - In any cycle where the data phase completes (WR with push, RD_DATA, ERR2), a new address phase may be accepted. The next state is taken from the new transfer; otherwise the FSM returns to IDLE.
  - At most one outstanding read.
- **IDLE/BUSY and unselected transfers:** zero-wait OKAY, no push.
- **Commands:**
  - Commands are pushed strictly in bus order.
  - fifo_wr_en never asserts while fifo_full=1.
  - rsp_rd_en never asserts while rsp_empty=1.

## Timing
- **Reset values:**
  - Outputs: HREADYOUT=1, HRESP=0, HRDATA=0, fifo_wr_en=0, fifo_wr_data=0, rsp_rd_en=0.
  - State: IDLE, captured registers cleared.
- **Reset mid-operation:** the in-flight transfer is abandoned. Commands already pushed remain in the FIFO. Draining them is a system-level concern.
- **Write latency:** address in cycle A; data phase completes in A+1 with zero wait states if fifo_full=0. Each fifo_full cycle adds one wait state.
- **Read latency:**
  - Push in A+1, RD_WAIT in A+2, pop in the first RD_WAIT cycle with rsp_empty=0, data returned the following cycle.
  - Minimum is 2 wait states (HREADYOUT low in A+1 and A+2, high in A+3).
- **fifo_wr_en and fifo_wr_data:** combinational from state and fifo_full. Sampled by the FIFO on the wr_clk edge that ends the cycle.
- **Wait-state rule:** HWDATA is held stable by the master during wait states, so a stalled write pushes the correct data.
- **Error response:** exactly 2 cycles; HRESP stays high across both.

## Test plan
- **Back-to-back writes:** 4 writes, fifo_full=0, HADDR 0x00/0x04/0x08/0x0C, data 0xA5A5_0001..4 → 4 pushes on consecutive cycles, words 0x1_00_A5A50001 … 0x1_0C_A5A50004, zero wait states.
- **Write under full:** write 0x10 / 0xDEADBEEF with fifo_full=1 for 3 cycles → 3 wait states, no push while full, single push 0x1_10_DEADBEEF on the first not-full cycle.
- **Read:** read 0x20, rsp_empty deasserted 5 cycles after address, rsp_data=0x1234_5678 → push 0x0_20_00000000, exactly one rsp_rd_en pulse, HRDATA=0x12345678 with HREADYOUT=1.
- **Illegal transfers:** HSIZE=3'b001, and separately HADDR=0x03 → two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1), no fifo_wr_en.
- **Idle/unselected traffic:** HTRANS=IDLE/BUSY with HSEL=1, and NONSEQ with HSEL=0 → HREADYOUT=1, HRESP=0, no pushes.
- **Reset:** assert wr_rst during RD_WAIT → all outputs reach reset values immediately. After release, a write to 0x04 completes with zero wait states.

Source files
------------

// File: rtl/ahb_fifo_writer.sv
// ahb_fifo_writer: AHB-Lite slave that turns bus transfers into command FIFO pushes and returns read data from the response FIFO
module ahb_fifo_writer #(
    parameter int DATA_WIDTH = 41,
    parameter int ADDR_BITS  = 8
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    input  logic                  fifo_full,
    output logic                  rsp_rd_en,
    input  logic [31:0]           rsp_data,
    input  logic                  rsp_empty
);
    typedef enum logic [2:0] {IDLE, WR, RD_CMD, RD_WAIT, RD_DATA, ERR1, ERR2} state_t;
    state_t state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic legal, done, accept;
    logic unused_bits;
    assign unused_bits = &{1'b0, HADDR[31:ADDR_BITS], HTRANS[0]};
    assign legal = HSIZE == 3'b010 && HADDR[1:0] == 2'b00;
    // a new address phase can only be taken in a cycle where the current data phase (if any) completes
    assign done = state_q == IDLE || state_q == RD_DATA || state_q == ERR2 || (state_q == WR && !fifo_full);
    assign accept = done && HSEL && HTRANS[1] && HREADY;
    // next state: pipelined accept wins, otherwise advance the current data phase
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (accept) begin
            state_d = !legal ? ERR1 : HWRITE ? WR : RD_CMD;
            addr_d  = HADDR[ADDR_BITS-1:0];
        end else if (done)
            state_d = IDLE;
        else if (state_q == RD_CMD && !fifo_full)
            state_d = RD_WAIT;
        else if (state_q == RD_WAIT && !rsp_empty)
            state_d = RD_DATA;
        else if (state_q == ERR1)
            state_d = ERR2;
    end
    // state and captured address; reset abandons any in-flight transfer
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end
    assign fifo_wr_en   = (state_q == WR || state_q == RD_CMD) && !fifo_full;
    assign fifo_wr_data = fifo_wr_en ? {state_q == WR, addr_q, state_q == WR ? HWDATA : 32'h0} : '0;
    assign rsp_rd_en    = state_q == RD_WAIT && !rsp_empty;
    assign HREADYOUT    = state_q == WR ? !fifo_full : !(state_q inside {RD_CMD, RD_WAIT, ERR1});
    assign HRESP        = state_q == ERR1 || state_q == ERR2;
    assign HRDATA       = state_q == RD_DATA ? rsp_data : 32'h0;
endmodule

// File: tb/tb_ahb_fifo_writer.sv
// tb_ahb_fifo_writer: scoreboard bench for the AHB command FIFO writer
module tb_ahb_fifo_writer;
    logic        wr_clk = 0, wr_rst = 0;
    logic        HSEL = 0, HWRITE = 0, HREADY, HREADYOUT, HRESP;
    logic [31:0] HADDR = 0, HWDATA = 0, HRDATA, rsp_data = 0;
    logic [1:0]  HTRANS = 0;
    logic [2:0]  HSIZE = 3'b010;
    logic        fifo_wr_en, fifo_full = 0, rsp_rd_en, rsp_empty = 1;
    logic [40:0] fifo_wr_data;

    typedef struct {bit err; bit rd; logic [31:0] rdata;} rsp_t;
    rsp_t        exp_rsp[$];
    logic [40:0] exp_cmd[$];
    logic [31:0] rd_plan[$], rsp_fifo[$];
    int tests = 0, fails = 0, cyc = 0, full_until = 0, rsp_hold = 0, last_waits = -1;
    bit rand_full = 0, rand_rsp = 0;
    bit in_dp = 0;
    int waits = 0, pops = 0;
    rsp_t mon_e;

    ahb_fifo_writer dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
        .rsp_rd_en(rsp_rd_en), .rsp_data(rsp_data), .rsp_empty(rsp_empty)
    );

    assign HREADY = HREADYOUT;
    always #5 wr_clk = ~wr_clk;
    always @(posedge wr_clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    // environment: command-side back-pressure, SPI-side response FIFO
    initial begin
        logic [31:0] v;
        bit popped;
        forever begin
            @(negedge wr_clk);
            popped = 0;
            if (!wr_rst && fifo_wr_en && !fifo_wr_data[40] && rd_plan.size() > 0)
                rsp_fifo.push_back(rd_plan.pop_front());
            if (!wr_rst && rsp_rd_en && rsp_fifo.size() > 0) begin
                v = rsp_fifo.pop_front();
                popped = 1;
            end
            @(posedge wr_clk);
            #1;
            if (popped) rsp_data = v;
            rsp_empty = !(rsp_fifo.size() > 0 && cyc >= rsp_hold && (!rand_rsp || $urandom_range(0, 1) == 1));
            fifo_full = cyc < full_until || (rand_full && $urandom_range(0, 2) == 0);
        end
    end

    // monitor: compares pushes and data-phase responses against the queues
    always @(negedge wr_clk) begin
        if (wr_rst) begin
            in_dp = 0;
            waits = 0;
            pops  = 0;
        end else begin
            if (fifo_wr_en) begin
                chk("push_while_full", {63'h0, fifo_full}, 64'h0);
                if (exp_cmd.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_push: actual %0h required none", fifo_wr_data);
                end else
                    chk("cmd_word", {23'h0, fifo_wr_data}, {23'h0, exp_cmd.pop_front()});
            end
            if (rsp_rd_en) begin
                chk("pop_while_empty", {63'h0, rsp_empty}, 64'h0);
                pops++;
            end
            if (in_dp && exp_rsp.size() > 0) begin
                mon_e = exp_rsp[0];
                chk("hresp", {63'h0, HRESP}, {63'h0, mon_e.err});
                if (!mon_e.err && !mon_e.rd)
                    chk("wr_wait_rule", {63'h0, HREADYOUT}, {63'h0, !fifo_full});
                if (HREADYOUT) begin
                    if (mon_e.err)
                        chk("err_waits", waits, 1);
                    else if (mon_e.rd) begin
                        chk("rd_min_waits", {63'h0, waits >= 2}, 64'h1);
                        chk("rd_pops", pops, 1);
                        chk("hrdata", {32'h0, HRDATA}, {32'h0, mon_e.rdata});
                    end
                    last_waits = waits;
                    void'(exp_rsp.pop_front());
                    in_dp = 0;
                end else
                    waits++;
            end else if (!in_dp)
                chk("idle_okay", {HREADYOUT, HRESP, HRDATA}, {1'b1, 1'b0, 32'h0});
            if (HSEL && HTRANS[1] && HREADY) begin
                in_dp = 1;
                waits = 0;
                pops  = 0;
            end
        end
    end

    task automatic xfer(bit sel, logic [1:0] trans, bit wr, logic [31:0] addr, logic [2:0] size,
                        logic [31:0] wdata, logic [31:0] rdata, int dly);
        bit lg, act, rdy;
        int g = 0;
        HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size;
        act = sel && trans[1];
        lg  = size == 3'b010 && addr[1:0] == 2'b00;
        if (act) begin
            exp_rsp.push_back('{!lg, !wr, rdata});
            if (lg) exp_cmd.push_back({wr, addr[7:0], wr ? wdata : 32'h0});
            if (lg && !wr) begin
                rd_plan.push_back(rdata);
                rsp_hold = cyc + dly;
            end
        end
        do begin
            @(negedge wr_clk);
            rdy = HREADY;
            @(posedge wr_clk);
            #1;
            g++;
        end while (!rdy && g < 300);
        if (!rdy) fail_now("addr_phase_timeout");
        if (act && wr) HWDATA = wdata;
    endtask

    task automatic idle();
        xfer(0, 2'b00, 0, 32'h0, 3'b010, 32'h0, 32'h0, 0);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_rsp.size() > 0 || exp_cmd.size() > 0) && g < 300) begin
            idle();
            g++;
        end
        if (exp_rsp.size() > 0 || exp_cmd.size() > 0) begin
            fail_now("drain_timeout");
            exp_rsp.delete();
            exp_cmd.delete();
        end
    endtask

    task automatic chk_reset_outputs(string name);
        chk(name, {HREADYOUT, HRESP, HRDATA, fifo_wr_en, rsp_rd_en}, {1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
        chk({name, "_word"}, {23'h0, fifo_wr_data}, 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 wr_rst = 1;
        #1 chk_reset_outputs("reset_state");
        repeat (3) @(posedge wr_clk);
        #1 wr_rst = 0;
        for (int i = 0; i < 4; i++)
            xfer(1, 2'b10 | (i > 0 ? 2'b01 : 2'b00), 1, i * 4, 3'b010, 32'hA5A5_0001 + i, 32'h0, 0);
        idle();
        drain();
        chk("b2b_last_waits", last_waits, 0);
        full_until = cyc + 4;
        xfer(1, 2'b10, 1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0);
        idle();
        drain();
        chk("full_waits", last_waits, 3);
        xfer(1, 2'b10, 0, 32'h20, 3'b010, 32'h0, 32'h1234_5678, 5);
        idle();
        drain();
        chk("rd_waits", last_waits, 5);
        xfer(1, 2'b10, 1, 32'h40, 3'b001, 32'h1, 32'h0, 0);
        xfer(1, 2'b10, 0, 32'h03, 3'b010, 32'h0, 32'h0, 0);
        idle();
        drain();
        chk("err_last_waits", last_waits, 1);
        xfer(1, 2'b00, 1, 32'h50, 3'b010, 32'h5, 32'h0, 0);
        xfer(1, 2'b01, 1, 32'h54, 3'b010, 32'h6, 32'h0, 0);
        xfer(0, 2'b10, 1, 32'h58, 3'b010, 32'h7, 32'h0, 0);
        idle();
        drain();
        rand_full = 1;
        rand_rsp  = 1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            xfer($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a,
                 $urandom_range(0, 9) == 0 ? 3'($urandom_range(0, 7)) : 3'b010,
                 $urandom(), $urandom(), $urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) idle();
        end
        rand_full = 0;
        rand_rsp  = 0;
        idle();
        drain();
        xfer(1, 2'b10, 0, 32'h30, 3'b010, 32'h0, 32'hCAFE_F00D, 1000);
        HSEL = 0;
        HTRANS = 2'b00;
        repeat (3) @(posedge wr_clk);
        #1 chk("rd_stalled", {63'h0, HREADYOUT}, 64'h0);
        wr_rst = 1;
        #1 chk_reset_outputs("mid_read_reset");
        exp_rsp.delete();
        exp_cmd.delete();
        rd_plan.delete();
        rsp_fifo.delete();
        rsp_hold = 0;
        @(posedge wr_clk);
        #1 wr_rst = 0;
        xfer(1, 2'b10, 1, 32'h04, 3'b010, 32'h0BAD_CAFE, 32'h0, 0);
        idle();
        drain();
        chk("post_reset_waits", last_waits, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
